// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the fetch PC and instruction-port bus transaction,
// applies redirects, and feeds the IF/ID register through a one-entry skid buffer.
module if_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h8000_0000,
    parameter logic [31:0] NOP_INSN   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] iport_addr,
    output logic        iport_stb,
    input  logic [31:0] iport_data,
    input  logic        iport_ack,
    input  logic        iport_err,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_op,
    input  logic [31:0] pc_branch_address,
    input  logic        jump_op,
    input  logic [31:0] pc_jump_address,
    input  logic        xcpt_take,
    input  logic [31:0] xcpt_pc,
    output logic [31:0] pc,
    output logic [31:0] pc_add4,
    output logic [31:0] instruction,
    output logic        if_valid,
    output logic        fetch_misaligned,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_SKID  = 2'd1,
        S_ABORT = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic        r_stb;
    logic [31:0] r_tgt;
    logic        r_skid_valid;
    logic [31:0] r_skid_insn;
    logic        r_skid_fault;
    logic [31:0] r_pc;
    logic [31:0] r_pc_add4;
    logic [31:0] r_insn;
    logic        r_valid;
    logic        r_mis;
    logic        r_fault;

    state_t      w_state;
    logic [31:0] w_fetch_pc;
    logic        w_stb;
    logic [31:0] w_tgt;
    logic        w_skid_valid;
    logic [31:0] w_skid_insn;
    logic        w_skid_fault;
    logic        w_ld;
    logic [31:0] w_ld_pc;
    logic [31:0] w_ld_insn;
    logic        w_ld_fault;
    logic        w_go;
    logic [31:0] w_go_pc;
    logic        w_mis;
    logic        w_redir;
    logic [31:0] w_redir_pc;
    logic        w_done;
    logic        w_accept;

    assign w_redir  = xcpt_take | jump_op | branch_op;
    assign w_done   = r_stb & (iport_ack | iport_err);
    assign w_accept = ~stall | ~r_valid;

    // Redirect target selection, exception first
    always_comb begin
        w_redir_pc = r_fetch_pc + 32'd4;
        if (xcpt_take) begin
            w_redir_pc = xcpt_pc;
        end else if (jump_op) begin
            w_redir_pc = pc_jump_address;
        end else if (branch_op) begin
            w_redir_pc = pc_branch_address;
        end else begin
            w_redir_pc = r_fetch_pc + 32'd4;
        end
    end

    // Next-state decode; w_go marks an immediate redirect applied after the case
    always_comb begin
        w_state      = r_state;
        w_fetch_pc   = r_fetch_pc;
        w_stb        = r_stb;
        w_tgt        = r_tgt;
        w_skid_valid = r_skid_valid;
        w_skid_insn  = r_skid_insn;
        w_skid_fault = r_skid_fault;
        w_ld         = 1'b0;
        w_ld_pc      = r_fetch_pc;
        w_ld_insn    = NOP_INSN;
        w_ld_fault   = 1'b0;
        w_go         = 1'b0;
        w_go_pc      = w_redir_pc;
        w_mis        = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_stb = 1'b1;
                if (w_redir) begin
                    if (r_stb && !w_done) begin
                        w_state = S_ABORT;
                        w_tgt   = w_redir_pc;
                    end else begin
                        w_go = 1'b1;
                    end
                end else if (r_stb && iport_err) begin
                    if (flush) begin
                        w_stb = 1'b1;
                    end else if (w_accept) begin
                        w_ld       = 1'b1;
                        w_ld_fault = 1'b1;
                        w_state    = S_HALT;
                        w_stb      = 1'b0;
                    end else begin
                        w_skid_valid = 1'b1;
                        w_skid_insn  = NOP_INSN;
                        w_skid_fault = 1'b1;
                        w_state      = S_SKID;
                        w_stb        = 1'b0;
                    end
                end else if (r_stb && iport_ack) begin
                    if (flush) begin
                        w_stb = 1'b1;
                    end else if (w_accept) begin
                        w_ld       = 1'b1;
                        w_ld_insn  = iport_data;
                        w_fetch_pc = r_fetch_pc + 32'd4;
                    end else begin
                        w_skid_valid = 1'b1;
                        w_skid_insn  = iport_data;
                        w_skid_fault = 1'b0;
                        w_state      = S_SKID;
                        w_stb        = 1'b0;
                    end
                end else begin
                    w_stb = 1'b1;
                end
            end
            S_SKID: begin
                w_stb = 1'b0;
                if (w_redir) begin
                    w_go = 1'b1;
                end else if (flush) begin
                    w_skid_valid = 1'b0;
                    w_state      = S_FETCH;
                    w_stb        = 1'b1;
                end else if (r_skid_valid && w_accept) begin
                    // the skid entry's PC is still fetch_pc; it only advances on drain
                    w_ld         = 1'b1;
                    w_ld_insn    = r_skid_insn;
                    w_ld_fault   = r_skid_fault;
                    w_skid_valid = 1'b0;
                    if (r_skid_fault) begin
                        w_state = S_HALT;
                    end else begin
                        w_state    = S_FETCH;
                        w_stb      = 1'b1;
                        w_fetch_pc = r_fetch_pc + 32'd4;
                    end
                end else begin
                    w_stb = 1'b0;
                end
            end
            S_ABORT: begin
                w_stb = 1'b1;
                if (w_done) begin
                    w_go    = 1'b1;
                    w_go_pc = w_redir ? w_redir_pc : r_tgt;
                end else if (w_redir) begin
                    w_tgt = w_redir_pc;
                end else begin
                    w_tgt = r_tgt;
                end
            end
            S_HALT: begin
                w_stb = 1'b0;
                if (w_redir) begin
                    w_go = 1'b1;
                end else begin
                    w_state = S_HALT;
                end
            end
            default: begin
                w_state = S_FETCH;
                w_stb   = 1'b0;
            end
        endcase
        if (w_go) begin
            w_fetch_pc   = w_go_pc;
            w_skid_valid = 1'b0;
            if (w_go_pc[1:0] != 2'b00) begin
                w_mis   = 1'b1;
                w_state = S_HALT;
                w_stb   = 1'b0;
            end else begin
                w_mis   = 1'b0;
                w_state = S_FETCH;
                w_stb   = 1'b1;
            end
        end else begin
            w_mis = 1'b0;
        end
    end

    // Fetch control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_FETCH;
            r_fetch_pc   <= RESET_ADDR;
            r_stb        <= 1'b0;
            r_tgt        <= RESET_ADDR;
            r_skid_valid <= 1'b0;
            r_skid_insn  <= NOP_INSN;
            r_skid_fault <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_fetch_pc   <= w_fetch_pc;
            r_stb        <= w_stb;
            r_tgt        <= w_tgt;
            r_skid_valid <= w_skid_valid;
            r_skid_insn  <= w_skid_insn;
            r_skid_fault <= w_skid_fault;
        end
    end

    // IF/ID register; a misaligned-target slot belongs to the new path so it beats flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= 32'd0;
            r_pc_add4 <= 32'd0;
            r_insn    <= NOP_INSN;
            r_valid   <= 1'b0;
            r_mis     <= 1'b0;
            r_fault   <= 1'b0;
        end else if (w_mis) begin
            r_pc      <= w_go_pc;
            r_pc_add4 <= w_go_pc + 32'd4;
            r_insn    <= NOP_INSN;
            r_valid   <= 1'b1;
            r_mis     <= 1'b1;
            r_fault   <= 1'b0;
        end else if (flush) begin
            r_insn    <= NOP_INSN;
            r_valid   <= 1'b0;
            r_mis     <= 1'b0;
            r_fault   <= 1'b0;
        end else if (w_ld) begin
            r_pc      <= w_ld_pc;
            r_pc_add4 <= w_ld_pc + 32'd4;
            r_insn    <= w_ld_insn;
            r_valid   <= 1'b1;
            r_mis     <= 1'b0;
            r_fault   <= w_ld_fault;
        end else if (stall && r_valid) begin
            r_insn    <= r_insn;
            r_valid   <= r_valid;
        end else begin
            r_insn    <= NOP_INSN;
            r_valid   <= 1'b0;
            r_mis     <= 1'b0;
            r_fault   <= 1'b0;
        end
    end

    assign iport_addr       = r_fetch_pc;
    assign iport_stb        = r_stb;
    assign pc               = r_pc;
    assign pc_add4          = r_pc_add4;
    assign instruction      = r_insn;
    assign if_valid         = r_valid;
    assign fetch_misaligned = r_mis;
    assign fetch_fault      = r_fault;

endmodule
